// File: rtl/learn_ctrl_pkg.sv
// learn_ctrl_pkg: state encoding, LFSR constants and helpers shared by the
// competitive-learning sequencer and its spike arbiter.
package learn_ctrl_pkg;

  // Sequencer states; the unused encoding recovers to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RANDOMIZE = 3'd1,
    ST_WAIT_PAT  = 3'd2,
    ST_PRESENT   = 3'd3,
    ST_HOLD      = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Cycles spent in RELEASE with learn/pre/post dropped.
  localparam int unsigned RELEASE_CYC = 2;

  // One Fibonacci LFSR step: feedback enters at the top, shift right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/learn_ctrl_rr_arbiter.sv
// rr_arbiter: picks one eligible neuron from a spike vector.
// LEARN_CTRL_RR_EN defined: round-robin from one past the last winner.
// LEARN_CTRL_RR_EN undefined: fixed priority, lowest eligible index wins.
module rr_arbiter
  import learn_ctrl_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
`ifdef LEARN_CTRL_RR_EN
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
`endif
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [N-1:0]     elig;
  logic             lo_hit;
  logic [IDX_W-1:0] lo_idx;

  // Committed neurons never compete.
  always_comb elig = req & ~mask;

  // Lowest eligible index over the whole vector.
  always_comb begin
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_hit = 1'b1;
        lo_idx = IDX_W'(i);
      end
    end
  end

`ifdef LEARN_CTRL_RR_EN
  logic [IDX_W-1:0] ptr;
  logic             hi_hit;
  logic [IDX_W-1:0] hi_idx;

  // Pointer moves to one past the winner, wrapping at N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx_c == IDX_W'(N - 1)) ? '0 : idx_c + IDX_W'(1);
    end
  end

  // Lowest eligible index at or above the pointer; else wrap to lowest overall.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (elig[i] && (IDX_W'(i) >= ptr)) begin
        hi_hit = 1'b1;
        hi_idx = IDX_W'(i);
      end
    end
    idx_c   = hi_hit ? hi_idx : lo_idx;
    grant_c = lo_hit ? (N'(1) << idx_c) : '0;
  end
`else
  // Fixed priority grant.
  always_comb begin
    idx_c   = lo_idx;
    grant_c = lo_hit ? (N'(1) << lo_idx) : '0;
  end
`endif

endmodule

// File: rtl/learn_ctrl.sv
// learn_ctrl: randomizes synapse weights, presents training patterns with
// learn high, arbitrates the first eligible output spike into one winner and
// holds its post line so the winner's synapses can commit.
// Optional build macro: LEARN_CTRL_RR_EN (round-robin spike arbitration).
module learn_ctrl
  import learn_ctrl_pkg::*;
#(
  parameter int unsigned N_PRE       = 8,
  parameter int unsigned N_POST      = 4,
  parameter int unsigned RAND_CYC    = 32,
  parameter int unsigned PRESENT_CYC = 64,
  parameter int unsigned POST_HOLD   = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      pat_valid,
  input  logic [N_PRE-1:0]          pat_data,
  output logic                      pat_ready,
  input  logic [N_POST-1:0]         post_spk,
  output logic                      learn,
  output logic [N_PRE-1:0]          pre,
  output logic                      random_weight,
  output logic [N_POST-1:0]         post_out,
  output logic [$clog2(N_POST)-1:0] winner,
  output logic                      winner_valid,
  output logic                      timeout,
  output logic                      busy,
  output logic                      full
);

  localparam int unsigned IDX_W   = $clog2(N_POST);
  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? LFSR_DEFAULT_SEED : LFSR_SEED;
  localparam int unsigned MAX_A   = (RAND_CYC > PRESENT_CYC) ? RAND_CYC : PRESENT_CYC;
  localparam int unsigned MAX_B   = (MAX_A > POST_HOLD) ? MAX_A : POST_HOLD;
  localparam int unsigned CNT_MAX = (MAX_B > RELEASE_CYC) ? MAX_B : RELEASE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt_c;
  logic [N_POST-1:0] spk_q;
  logic [N_POST-1:0] mask;
  logic              has_win;
  logic [N_POST-1:0] grant_c;
  logic [IDX_W-1:0]  idx_c;
  logic              hit_c;

  // Raw spikes are registered once before arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spk_q <= '0;
    else        spk_q <= post_spk;
  end

  // Next LFSR value, used only while randomizing.
  always_comb lfsr_nxt_c = lfsr_next(lfsr);

  // Any eligible spike this cycle.
  always_comb hit_c = |grant_c;

`ifdef LEARN_CTRL_RR_EN
  logic arb_adv_c;

  // Round-robin pointer follows each accepted winner.
  always_comb arb_adv_c = (state == ST_PRESENT) && hit_c;
`endif

  rr_arbiter #(.N(N_POST)) u_arb (
`ifdef LEARN_CTRL_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (arb_adv_c),
`endif
    .req     (spk_q),
    .mask    (mask),
    .grant_c (grant_c),
    .idx_c   (idx_c)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      lfsr          <= SEED;
      mask          <= '0;
      has_win       <= 1'b0;
      pat_ready     <= 1'b0;
      learn         <= 1'b0;
      pre           <= '0;
      random_weight <= 1'b0;
      post_out      <= '0;
      winner        <= '0;
      winner_valid  <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
      full          <= 1'b0;
    end else begin
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_RANDOMIZE;
            cnt           <= '0;
            mask          <= '0;
            busy          <= 1'b1;
            full          <= 1'b0;
            random_weight <= lfsr[0];
          end
        end
        ST_RANDOMIZE: begin
          lfsr <= lfsr_nxt_c;
          if (cnt == CNT_W'(RAND_CYC - 1)) begin
            state         <= ST_WAIT_PAT;
            cnt           <= '0;
            random_weight <= 1'b0;
          end else begin
            cnt           <= cnt + CNT_W'(1);
            random_weight <= lfsr_nxt_c[0];
          end
        end
        ST_WAIT_PAT: begin
          if (&mask) begin
            state     <= ST_DONE;
            full      <= 1'b1;
            busy      <= 1'b0;
            pat_ready <= 1'b0;
          end else if (pat_valid && pat_ready) begin
            state     <= ST_PRESENT;
            pat_ready <= 1'b0;
            pre       <= pat_data;
            learn     <= 1'b1;
            cnt       <= '0;
            has_win   <= 1'b0;
          end else begin
            pat_ready <= 1'b1;
          end
        end
        ST_PRESENT: begin
          // A spike on the expiry cycle still wins.
          if (hit_c) begin
            state   <= ST_HOLD;
            winner  <= idx_c;
            has_win <= 1'b1;
            cnt     <= '0;
          end else if (cnt == CNT_W'(PRESENT_CYC - 1)) begin
            state   <= ST_RELEASE;
            timeout <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          post_out <= N_POST'(1) << winner;
          if (cnt == CNT_W'(POST_HOLD - 1)) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == '0) begin
            learn    <= 1'b0;
            pre      <= '0;
            post_out <= '0;
            if (has_win) begin
              mask         <= mask | (N_POST'(1) << winner);
              winner_valid <= 1'b1;
              has_win      <= 1'b0;
            end
          end
          if (cnt == CNT_W'(RELEASE_CYC - 1)) begin
            state <= ST_WAIT_PAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state         <= ST_IDLE;
          cnt           <= '0;
          has_win       <= 1'b0;
          pat_ready     <= 1'b0;
          learn         <= 1'b0;
          pre           <= '0;
          random_weight <= 1'b0;
          post_out      <= '0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
